// File: rtl/dmem_seq_ctrl_if.sv
// Control bundle between the decoder top-level controller and the D-memory slot sequencer.
// The master side issues run requests; the slave side (the sequencer) drives the memory controls and status.
interface dmem_seq_ctrl_if #(
   parameter int ADDRESSWIDTH = 5,
   parameter int ITW          = 5
);
   logic                    start;
   logic [ITW-1:0]          max_iter;
   logic                    early_stop;
   logic                    rd_en;
   logic [ADDRESSWIDTH-1:0] rd_address;
   logic                    rd_layer;
   logic                    wr_en;
   logic                    first_iter;
   logic [ITW-1:0]          iter_count;
   logic                    busy;
   logic                    done;

   modport master (
      output start, max_iter, early_stop,
      input  rd_en, rd_address, rd_layer, wr_en, first_iter, iter_count, busy, done
   );

   modport slave (
      input  start, max_iter, early_stop,
      output rd_en, rd_address, rd_layer, wr_en, first_iter, iter_count, busy, done
   );
endinterface

// File: rtl/dmem_seq_ctrl.sv
// Slot sequencer for the two-layer LDPC D shift-register-queue memory: walks layer/address slots per
// iteration, delays each slot by PIPE cycles into wr_en, and reports iteration count and completion.
module dmem_seq_ctrl #(
   parameter int ADDRESSWIDTH = 5,
   parameter int NCYC         = 20,
   parameter int PIPE         = 4,
   parameter int ITW          = 5
) (
   input  logic              clk,
   input  logic              rst,
   dmem_seq_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FIN
   } state_e;

   localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(NCYC - 1);

   state_e                  state_q, state_d;
   logic [ADDRESSWIDTH-1:0] rd_address_q, rd_address_d;
   logic                    rd_layer_q, rd_layer_d;
   logic                    rd_en_q, rd_en_d;
   logic                    first_iter_q, first_iter_d;
   logic [ITW-1:0]          iter_count_q, iter_count_d;
   logic [ITW-1:0]          limit_q, limit_d;
   logic [PIPE-1:0]         pipe_q, pipe_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic                    last_slot;
   logic [ITW-1:0]          iter_inc;

   // NOTE: every signal gets its hold/default value first so no path through the case leaves a latch.
   always_comb begin
      state_d      = state_q;
      rd_address_d = rd_address_q;
      rd_layer_d   = rd_layer_q;
      rd_en_d      = rd_en_q;
      first_iter_d = first_iter_q;
      iter_count_d = iter_count_q;
      limit_d      = limit_q;

      last_slot = rd_layer_q && (rd_address_q == LAST_ADDR);
      iter_inc  = (&iter_count_q) ? iter_count_q : iter_count_q + 1'b1;
      // Each presented slot launches a valid bit that surfaces PIPE cycles later as wr_en.
      pipe_d    = (pipe_q << 1) | PIPE'(state_q == S_RUN);

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d      = S_RUN;
               limit_d      = (bus.max_iter == '0) ? ITW'(1) : bus.max_iter;
               iter_count_d = '0;
               rd_address_d = '0;
               rd_layer_d   = 1'b0;
               first_iter_d = 1'b1;
               rd_en_d      = 1'b0;
            end
         end

         S_RUN: begin
            if (last_slot) begin
               iter_count_d = iter_inc;
               rd_address_d = '0;
               rd_layer_d   = 1'b0;
               first_iter_d = 1'b0;
               if ((iter_inc == limit_q) || bus.early_stop) begin
                  state_d = S_DRAIN;
                  rd_en_d = 1'b0;
               end else begin
                  rd_en_d = 1'b1;
               end
            end else if (rd_address_q == LAST_ADDR) begin
               rd_address_d = '0;
               rd_layer_d   = 1'b1;
            end else begin
               rd_address_d = rd_address_q + 1'b1;
            end
         end

         S_DRAIN: begin
            if (pipe_d == '0) begin
               state_d = S_FIN;
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FIN);
   end

   // NOTE: state uses non-blocking assignments and the async reset clears the delay line as well,
   // so writes in flight at reset never reach the memory.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         rd_address_q <= '0;
         rd_layer_q   <= 1'b0;
         rd_en_q      <= 1'b0;
         first_iter_q <= 1'b0;
         iter_count_q <= '0;
         limit_q      <= '0;
         pipe_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_address_q <= rd_address_d;
         rd_layer_q   <= rd_layer_d;
         rd_en_q      <= rd_en_d;
         first_iter_q <= first_iter_d;
         iter_count_q <= iter_count_d;
         limit_q      <= limit_d;
         pipe_q       <= pipe_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.rd_en      = rd_en_q;
   assign bus.rd_address = rd_address_q;
   assign bus.rd_layer   = rd_layer_q;
   assign bus.wr_en      = pipe_q[PIPE-1];
   assign bus.first_iter = first_iter_q;
   assign bus.iter_count = iter_count_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_dmem_seq_ctrl.sv
// Self-checking bench for dmem_seq_ctrl: per-cycle expected outputs are derived from the run timing
// and queued when start is driven, then popped and compared each cycle.
module tb_dmem_seq_ctrl;

   localparam int AW    = 5;
   localparam int NC    = 20;
   localparam int PP    = 4;
   localparam int IW    = 5;
   localparam int SLOTS = 2 * NC;

   typedef struct packed {
      logic          rd_en;
      logic [AW-1:0] addr;
      logic          layer;
      logic          wr_en;
      logic          first;
      logic [IW-1:0] iter;
      logic          busy;
      logic          done;
   } obs_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   obs_t sb[$];

   dmem_seq_ctrl_if #(.ADDRESSWIDTH(AW), .ITW(IW)) bus ();

   dmem_seq_ctrl #(
      .ADDRESSWIDTH(AW),
      .NCYC        (NC),
      .PIPE        (PP),
      .ITW         (IW)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs in cycle c of a run that lasts n iterations (start sampled at end of cycle 0).
   function automatic obs_t model(int c, int n);
      obs_t e;
      int   s;
      int   last;
      int   it;
      e    = '0;
      s    = c - 1;
      last = SLOTS * n;
      if (c >= 1 && c <= last) begin
         e.addr  = AW'(s % NC);
         e.layer = ((s / NC) % 2) == 1;
         e.first = (s < SLOTS);
         e.rd_en = (s >= SLOTS);
      end
      e.wr_en = (c >= 1 + PP) && (c <= last + PP);
      e.busy  = (c >= 1) && (c <= last + PP + 1);
      e.done  = (c == last + PP + 1);
      it      = (c - 1) / SLOTS;
      e.iter  = IW'((it < n) ? it : n);
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.rd_en = bus.rd_en;
      o.addr  = bus.rd_address;
      o.layer = bus.rd_layer;
      o.wr_en = bus.wr_en;
      o.first = bus.first_iter;
      o.iter  = bus.iter_count;
      o.busy  = bus.busy;
      o.done  = bus.done;
      return o;
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("rd_en=%b adr=%0d lay=%b wr=%b fi=%b it=%0d busy=%b done=%b",
                       o.rd_en, o.addr, o.layer, o.wr_en, o.first, o.iter, o.busy, o.done);
   endfunction

   task automatic push_run(int n, int last_c);
      for (int k = 1; k <= last_c; k++) sb.push_back(model(k, n));
   endtask

   // Inputs for cycle c; max_iter is scrambled outside the start cycle to prove it is latched.
   task automatic drive(int c, int mi, int es_a, int es_b, int st_a, int st_b);
      bus.start      = (c == 0) || (c == st_a) || (c == st_b);
      bus.max_iter   = (c == 0) ? IW'(mi) : IW'($urandom_range(0, 31));
      bus.early_stop = (c == es_a) || (c == es_b);
   endtask

   task automatic test_reset();
      obs_t got;
      #2;
      got = sample();
      checks++;
      if (got !== obs_t'(0)) begin
         errors++;
         $display("FAIL reset_state got %s want all zero", fmt(got));
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== obs_t'(0)) begin
         errors++;
         $display("FAIL idle_after_reset got %s want all zero", fmt(got));
      end
   endtask

   task automatic test_single_iter();
      obs_t exp_v, got;
      int   last_c = SLOTS + PP + 1 + 2;
      for (int c = 0; c <= last_c; c++) begin
         @(negedge clk);
         if (c == 0) push_run(1, last_c);
         else begin
            exp_v = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL single_iter c%0d got %s want %s", c, fmt(got), fmt(exp_v));
            end
         end
         drive(c, 1, -1, -1, -1, -1);
      end
   endtask

   task automatic test_two_iter();
      obs_t exp_v, got;
      int   last_c = 2 * SLOTS + PP + 1 + 2;
      for (int c = 0; c <= last_c; c++) begin
         @(negedge clk);
         if (c == 0) push_run(2, last_c);
         else begin
            exp_v = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL two_iter c%0d got %s want %s", c, fmt(got), fmt(exp_v));
            end
         end
         drive(c, 2, -1, -1, -1, -1);
      end
   endtask

   task automatic test_early_stop();
      obs_t exp_v, got;
      int   last_c = 2 * SLOTS + PP + 1 + 2;
      for (int c = 0; c <= last_c; c++) begin
         @(negedge clk);
         if (c == 0) push_run(2, last_c);
         else begin
            exp_v = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL early_stop c%0d got %s want %s", c, fmt(got), fmt(exp_v));
            end
         end
         drive(c, 5, 30, 2 * SLOTS, -1, -1);
      end
   endtask

   task automatic test_max_iter_zero();
      obs_t exp_v, got;
      int   last_c = SLOTS + PP + 1 + 2;
      for (int c = 0; c <= last_c; c++) begin
         @(negedge clk);
         if (c == 0) push_run(1, last_c);
         else begin
            exp_v = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL max_iter_zero c%0d got %s want %s", c, fmt(got), fmt(exp_v));
            end
         end
         drive(c, 0, -1, -1, -1, -1);
      end
   endtask

   task automatic test_limit_and_stop();
      obs_t exp_v, got;
      int   last_c = SLOTS + PP + 1 + 2;
      for (int c = 0; c <= last_c; c++) begin
         @(negedge clk);
         if (c == 0) push_run(1, last_c);
         else begin
            exp_v = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL limit_and_stop c%0d got %s want %s", c, fmt(got), fmt(exp_v));
            end
         end
         drive(c, 1, SLOTS, -1, -1, -1);
      end
   endtask

   task automatic test_start_ignored();
      obs_t exp_v, got;
      int   last_c = SLOTS + PP + 1 + 4;
      for (int c = 0; c <= last_c; c++) begin
         @(negedge clk);
         if (c == 0) push_run(1, last_c);
         else begin
            exp_v = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL start_ignored c%0d got %s want %s", c, fmt(got), fmt(exp_v));
            end
         end
         drive(c, 1, -1, -1, 10, SLOTS + PP + 1);
      end
   endtask

   // First run ends on its done cycle; the second start lands in the very next cycle.
   task automatic test_back_to_back();
      obs_t exp_v, got;
      int   last_a = SLOTS + PP + 1;
      int   last_b = 2 * SLOTS + PP + 1 + 2;
      for (int c = 0; c <= last_a; c++) begin
         @(negedge clk);
         if (c == 0) push_run(1, last_a);
         else begin
            exp_v = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL back_to_back_a c%0d got %s want %s", c, fmt(got), fmt(exp_v));
            end
         end
         drive(c, 1, -1, -1, -1, -1);
      end
      for (int c = 0; c <= last_b; c++) begin
         @(negedge clk);
         if (c == 0) push_run(2, last_b);
         else begin
            exp_v = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL back_to_back_b c%0d got %s want %s", c, fmt(got), fmt(exp_v));
            end
         end
         drive(c, 2, -1, -1, -1, -1);
      end
   endtask

   task automatic test_reset_midrun();
      obs_t exp_v, got;
      for (int c = 0; c <= 30; c++) begin
         @(negedge clk);
         if (c == 0) push_run(2, 30);
         else begin
            exp_v = sb.pop_front();
            got   = sample();
            checks++;
            if (got !== exp_v) begin
               errors++;
               $display("FAIL reset_midrun_pre c%0d got %s want %s", c, fmt(got), fmt(exp_v));
            end
         end
         drive(c, 2, -1, -1, -1, -1);
      end
      rst       = 1'b0;
      bus.start = 1'b0;
      #1;
      got = sample();
      checks++;
      if (got !== obs_t'(0)) begin
         errors++;
         $display("FAIL reset_midrun_immediate got %s want all zero", fmt(got));
      end
      for (int k = 0; k < PP + 2; k++) begin
         @(negedge clk);
         got = sample();
         checks++;
         if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_midrun_hold k%0d got %s want all zero", k, fmt(got));
         end
      end
      rst = 1'b1;
      for (int k = 0; k < PP + 2; k++) begin
         @(negedge clk);
         got = sample();
         checks++;
         if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_midrun_release k%0d got %s want all zero", k, fmt(got));
         end
      end
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      rst            = 1'b0;
      bus.start      = 1'b0;
      bus.max_iter   = '0;
      bus.early_stop = 1'b0;

      test_reset();
      test_single_iter();
      test_two_iter();
      test_early_stop();
      test_max_iter_zero();
      test_limit_and_stop();
      test_start_ignored();
      test_back_to_back();
      test_reset_midrun();
      test_two_iter();

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
